// File: rtl/mips_bus_pkg.sv
// Shared definitions for the fetch/load-store memory bus arbiter.
package mips_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    XFER_I,
    XFER_D,
    DONE_I,
    DONE_D
  } arb_state_t;

  localparam logic MST_INST = 1'b0;
  localparam logic MST_DATA = 1'b1;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  localparam logic [3:0] WSTRB_NONE = 4'b0000;

endpackage

// File: rtl/bus_watchdog.sv
// Bus-cycle watchdog: counts silent transfer cycles and flags the one that
// reaches TIMEOUT. TIMEOUT == 0 turns the watchdog off.
module bus_watchdog
  import mips_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [31:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 32'd1;
    end
  end

  // Fires in the cycle whose increment would bring the count to TIMEOUT.
  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = enable && (count == TIMEOUT - 32'd1);
    end
  endgenerate

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-ported memory bus arbiter for the fetch and load/store stages:
// alternating grants on contention, flush squashing and bus-cycle watchdog.
module mem_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_flush,
  output logic [31:0] inst_rdata,
  output logic        inst_ready,
  output logic        inst_stall,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ready,
  output logic        data_stall,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  arb_state_t state;
  logic       last_grant;
  logic       squash;
  logic       inst_done;
  logic       err_flag;
  logic       grant_data;
  logic       in_xfer;
  logic       wd_clear;
  logic       wd_enable;
  logic       wd_expired;

  assign grant_data = data_req && (!inst_req || (last_grant == MST_INST));
  assign in_xfer    = (state == XFER_I) || (state == XFER_D);
  assign wd_clear   = (state == IDLE) && (inst_req || data_req);
  assign wd_enable  = in_xfer && !mem_ack;

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= MST_INST;
      squash     <= 1'b0;
      inst_done  <= 1'b0;
      data_ready <= 1'b0;
      err_flag   <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
      mem_req    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wstrb  <= WSTRB_NONE;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      inst_done  <= 1'b0;
      data_ready <= 1'b0;
      err_flag   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_data) begin
            state      <= XFER_D;
            last_grant <= MST_DATA;
            mem_req    <= 1'b1;
            mem_wr     <= data_wr;
            mem_wstrb  <= data_wr ? data_wstrb : WSTRB_NONE;
            mem_addr   <= data_addr;
            mem_wdata  <= data_wdata;
          end else if (inst_req) begin
            state      <= XFER_I;
            last_grant <= MST_INST;
            squash     <= inst_flush;
            mem_req    <= 1'b1;
            mem_wr     <= 1'b0;
            mem_wstrb  <= WSTRB_NONE;
            mem_addr   <= inst_addr;
            mem_wdata  <= '0;
          end
        end
        XFER_I: begin
          if (inst_flush) begin
            squash <= 1'b1;
          end
          if (mem_ack || wd_expired) begin
            state      <= DONE_I;
            mem_req    <= 1'b0;
            inst_rdata <= mem_ack ? mem_rdata : '0;
            inst_done  <= 1'b1;
            err_flag   <= !mem_ack;
          end
        end
        XFER_D: begin
          if (mem_ack || wd_expired) begin
            state      <= DONE_D;
            mem_req    <= 1'b0;
            data_rdata <= (mem_ack && !mem_wr) ? mem_rdata : '0;
            data_ready <= 1'b1;
            err_flag   <= !mem_ack;
          end
        end
        DONE_I, DONE_D: begin
          state  <= IDLE;
          squash <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          squash <= 1'b0;
        end
      endcase
    end
  end

  // A flush arriving in the completion cycle itself must still kill the
  // fetch response, so the registered pulse is gated here.
  assign inst_ready = inst_done && !squash && !inst_flush;
  assign bus_err    = err_flag && !(inst_done && (squash || inst_flush));

  assign inst_stall = inst_req && !inst_ready;
  assign data_stall = data_req && !data_ready;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// randomized traffic against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int unsigned TO = 4;
  localparam int NONE = 99;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_flush;
  logic [31:0] inst_rdata;
  logic        inst_ready;
  logic        inst_stall;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ready;
  logic        data_stall;
  logic        bus_err;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;
  bit last_inst;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_flush(inst_flush),
    .inst_rdata(inst_rdata), .inst_ready(inst_ready), .inst_stall(inst_stall),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_ready(data_ready), .data_stall(data_stall), .bus_err(bus_err),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One arbitrated transaction from the IDLE cycle to the next IDLE cycle.
  // delay: XFER cycles before ack; flush_at: 0=IDLE, n=XFER cycle n, -1=DONE.
  task automatic txn(input int delay, input logic [31:0] rd, input int flush_at);
    bit          win_inst, acked, timed_out, squashed;
    logic [31:0] exp_addr, exp_rd;
    logic        exp_wr;
    logic [3:0]  exp_strb;
    win_inst = inst_req && !(data_req && last_inst);
    if (win_inst) begin
      exp_addr = inst_addr; exp_wr = 1'b0; exp_strb = 4'b0000;
    end else begin
      exp_addr = data_addr; exp_wr = data_wr;
      exp_strb = data_wr ? data_wstrb : 4'b0000;
    end
    squashed   = (flush_at == 0) && win_inst;
    inst_flush = (flush_at == 0);
    cyc();
    inst_flush = 1'b0;
    chk("grant_mem_req", mem_req, 1);
    chk("grant_mem_addr", mem_addr, exp_addr);
    chk("grant_mem_wr", mem_wr, exp_wr);
    chk("grant_mem_wstrb", mem_wstrb, exp_strb);
    if (exp_wr) chk("grant_mem_wdata", mem_wdata, data_wdata);
    chk("xfer_inst_stall", inst_stall, inst_req);
    chk("xfer_data_stall", data_stall, data_req);
    acked = 0;
    timed_out = 0;
    for (int c = 1; c <= int'(TO); c++) begin
      if (c == delay + 1) begin mem_ack = 1'b1; mem_rdata = rd; end
      if (c == flush_at) begin inst_flush = 1'b1; if (win_inst) squashed = 1; end
      cyc();
      mem_ack    = 1'b0;
      inst_flush = 1'b0;
      mem_rdata  = $urandom;
      if (c == delay + 1) begin acked = 1; break; end
      if (c == int'(TO)) begin timed_out = 1; break; end
      chk("xfer_mem_req_held", mem_req, 1);
      chk("xfer_no_ready", {inst_ready, data_ready, bus_err}, 0);
    end
    if (flush_at < 0) begin
      inst_flush = 1'b1;
      if (win_inst) squashed = 1;
      #1;
    end
    exp_rd = (acked && (win_inst || !data_wr)) ? rd : 32'h0;
    chk("done_mem_req", mem_req, 0);
    chk("done_inst_ready", inst_ready, win_inst && !squashed);
    chk("done_data_ready", data_ready, !win_inst);
    chk("done_bus_err", bus_err, timed_out && !(win_inst && squashed));
    if (win_inst && !squashed) chk("done_inst_rdata", inst_rdata, exp_rd);
    if (!win_inst) chk("done_data_rdata", data_rdata, exp_rd);
    chk("done_inst_stall", inst_stall, inst_req && !(win_inst && !squashed));
    chk("done_data_stall", data_stall, data_req && win_inst);
    last_inst = win_inst;
    if (win_inst) inst_req = 1'b0;
    else data_req = 1'b0;
    cyc();
    inst_flush = 1'b0;
    chk("idle_pulses_clear", {inst_ready, data_ready, bus_err}, 0);
    chk("idle_mem_req", mem_req, 0);
  endtask

  initial begin
    int r;
    rst = 1'b0;
    inst_req = 0; inst_addr = '0; inst_flush = 0;
    data_req = 0; data_wr = 0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    last_inst = 1;
    cyc();
    cyc();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_pulses", {inst_ready, data_ready, bus_err}, 0);
    chk("rst_rdata", inst_rdata | data_rdata, 0);
    rst = 1'b1;
    cyc();

    // Fetch alone
    inst_req = 1; inst_addr = 32'hBFC0_0000;
    #1 chk("fetch_stall_on_req", inst_stall, 1);
    txn(2, 32'h2408_0001, NONE);

    // Contention: store first, then fetch, then alternating
    inst_req = 1; inst_addr = 32'hBFC0_0004;
    data_req = 1; data_wr = 1; data_addr = 32'h8000_0010;
    data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'b0011;
    txn(0, 32'h1234_5678, NONE);
    txn(1, 32'h1111_1111, NONE);
    inst_req = 1; inst_addr = 32'hBFC0_0008;
    data_req = 1; data_wr = 0; data_addr = 32'h8000_0020; data_wstrb = 4'b1111;
    txn(0, 32'hCAFE_0001, NONE);
    data_req = 1; data_wr = 0; data_addr = 32'h8000_0024;
    txn(1, 32'h2222_2222, NONE);
    txn(0, 32'hCAFE_0002, NONE);

    // Squash during XFER, in IDLE grant and in DONE; then a clean fetch
    inst_req = 1; inst_addr = 32'hBFC0_0100;
    txn(2, 32'h3333_3333, 2);
    inst_req = 1; inst_addr = 32'hBFC0_0104;
    txn(0, 32'h4444_4444, NONE);
    inst_req = 1; inst_addr = 32'hBFC0_0108;
    txn(1, 32'h5555_5555, 0);
    inst_req = 1; inst_addr = 32'hBFC0_010C;
    txn(0, 32'h6666_6666, -1);

    // Timeout on a load and a fetch; ack coincident with expiry
    data_req = 1; data_wr = 0; data_addr = 32'h8000_0040;
    txn(10, 32'h7777_7777, NONE);
    inst_req = 1; inst_addr = 32'hBFC0_0200;
    txn(10, 32'h8888_8888, NONE);
    data_req = 1; data_wr = 0; data_addr = 32'h8000_0044;
    txn(int'(TO) - 1, 32'h9999_9999, NONE);

    // Asynchronous reset in the middle of a data transfer
    data_req = 1; data_wr = 1; data_addr = 32'h8000_0050; data_wstrb = 4'b1000;
    cyc();
    chk("pre_reset_mem_req", mem_req, 1);
    rst = 1'b0;
    #1;
    chk("reset_mem_req", mem_req, 0);
    chk("reset_mem_wr", mem_wr, 0);
    chk("reset_mem_addr", mem_addr, 0);
    data_req = 0;
    last_inst = 1;
    @(negedge clk);
    rst = 1'b1;
    inst_req = 1; inst_addr = 32'hBFC0_0300;
    txn(0, 32'hABCD_0003, NONE);

    // Randomized traffic
    repeat (80) begin
      if (!inst_req && $urandom_range(0, 2) != 0) begin
        inst_req = 1; inst_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_req && $urandom_range(0, 2) != 0) begin
        data_req = 1; data_wr = 1'($urandom); data_addr = $urandom;
        data_wdata = $urandom; data_wstrb = 4'($urandom);
      end
      if (!inst_req && !data_req) begin
        cyc();
        chk("rand_idle_mem_req", mem_req, 0);
      end else begin
        r = $urandom_range(0, 9);
        txn($urandom_range(0, 5), $urandom,
            (r == 0) ? 0 : (r == 1) ? -1 : (r == 2) ? $urandom_range(1, 4) : NONE);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
